// File: rtl/craft_pkg.sv
// rtl/craft_pkg.sv - shared constants, state encoding and round-constant LFSR steps for CRAFT
package craft_pkg;

  localparam int CRAFT_ROUNDS  = 32;
  localparam int CRAFT_NIBBLES = 16;

  localparam logic [3:0] RC_A_INIT = 4'h1;
  localparam logic [2:0] RC_B_INIT = 3'h1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

  function automatic logic [3:0] rc_a_step(input logic [3:0] a);
    return {a[1] ^ a[0], a[3:1]};
  endfunction

  function automatic logic [2:0] rc_b_step(input logic [2:0] b);
    return {b[1] ^ b[0], b[2:1]};
  endfunction

endpackage

// File: rtl/craft_rc_lfsr.sv
// rtl/craft_rc_lfsr.sv - paired 4-bit/3-bit LFSRs producing the 8-bit CRAFT round constant
module craft_rc_lfsr
  import craft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] rc
);

  logic [3:0] a;
  logic [2:0] b;

  // load wins over step so a restart always begins from RC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= RC_A_INIT;
      b <= RC_B_INIT;
    end else if (load) begin
      a <= RC_A_INIT;
      b <= RC_B_INIT;
    end else if (step) begin
      a <= rc_a_step(a);
      b <= rc_b_step(b);
    end
  end

  assign rc = {a, 1'b0, b};

endmodule

// File: rtl/craft_round_ctrl.sv
// rtl/craft_round_ctrl.sv - round/nibble sequencer driving the CRAFT key register and AddConstant
module craft_round_ctrl
  import craft_pkg::*;
#(
  parameter int NUM_ROUNDS   = CRAFT_ROUNDS,
  parameter int ROUND_CYCLES = CRAFT_NIBBLES,
  parameter int RW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          en,
  output logic          ck0,
  output logic [RW-1:0] r,
  output logic [3:0]    nib_idx,
  output logic [7:0]    rc,
  output logic          last_round
);

  localparam logic [3:0]    NIB_LAST   = 4'(ROUND_CYCLES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS - 1);

  state_t state, state_next;
  logic   accept;
  logic   advance;
  logic   nib_last;
  logic   round_last;

  assign accept     = (state == ST_IDLE) & start;
  assign advance    = (state == ST_RUN) & ~stall;
  assign nib_last   = (nib_idx == NIB_LAST);
  assign round_last = (r == ROUND_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (advance && nib_last && round_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // On the final nibble of the final round the counters hold; DONE takes over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r       <= '0;
      nib_idx <= '0;
    end else if (accept) begin
      r       <= '0;
      nib_idx <= '0;
    end else if (advance) begin
      if (nib_last) begin
        if (!round_last) begin
          nib_idx <= '0;
          r       <= r + 1'b1;
        end
      end else begin
        nib_idx <= nib_idx + 1'b1;
      end
    end
  end

  craft_rc_lfsr u_rc_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (advance & nib_last & ~round_last),
    .rc   (rc)
  );

  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign en         = busy & ~stall;
  assign ck0        = busy & (nib_idx == 4'd0);
  assign last_round = busy & round_last;

endmodule

// File: tb/tb_craft_round_ctrl.sv
// tb/tb_craft_round_ctrl.sv - scoreboard bench for craft_round_ctrl with randomized stalls and restarts
`timescale 1ns/1ps
module tb_craft_round_ctrl;

  typedef struct {
    bit is_done;
    int r;
    int rc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       busy, done, en, ck0, last_round;
  logic [7:0] r;
  logic [3:0] nib_idx;
  logic [7:0] rc;

  int checks = 0;
  int errors = 0;

  int   rc_tab[32];
  int   rc_lit[5];
  exp_t q[$];

  int cyc       = 0;
  int m_phase   = 0;
  int m_prog    = 0;
  int m_stalls  = 0;
  int m_t_start = 0;
  bit m_fresh   = 1'b1;
  int en_cnt    = 0;

  craft_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .en         (en),
    .ck0        (ck0),
    .r          (r),
    .nib_idx    (nib_idx),
    .rc         (rc),
    .last_round (last_round)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: progress measured in completed nibbles, 512 per encryption
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_prog   <= 0;
      m_stalls <= 0;
      m_fresh  <= 1'b1;
      q.delete();
    end else begin
      cyc <= cyc + 1;
      case (m_phase)
        0: if (start) begin
          m_phase   <= 1;
          m_prog    <= 0;
          m_stalls  <= 0;
          m_t_start <= cyc + 1;
          m_fresh   <= 1'b0;
          for (int i = 0; i < 32; i++) q.push_back('{1'b0, i, rc_tab[i]});
          q.push_back('{1'b1, 0, 0});
        end
        1: begin
          if (stall)              m_stalls <= m_stalls + 1;
          else if (m_prog == 511) m_phase  <= 2;
          else                    m_prog   <= m_prog + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    bit   eb;
    exp_t it;
    if (rst) begin
      en_cnt = 0;
    end else begin
      eb = (m_phase == 1);
      chk("busy", busy, eb);
      chk("en", en, eb && !stall);
      chk("done", done, m_phase == 2);
      chk("ck0", ck0, eb && (m_prog % 16 == 0));
      chk("last_round", last_round, eb && (m_prog / 16 == 31));
      if (eb) begin
        chk("r", r, m_prog / 16);
        chk("nib_idx", nib_idx, m_prog % 16);
        chk("rc", rc, rc_tab[m_prog / 16]);
      end else if (m_fresh) begin
        chk("idle_r", r, 0);
        chk("idle_nib", nib_idx, 0);
        chk("idle_rc", rc, 'h11);
      end
      if (en) en_cnt++;
      if (ck0 && en) begin
        if (q.size() == 0) chk("ck0_unexpected", 1, 0);
        else begin
          it = q.pop_front();
          chk("ck0_item_kind", it.is_done, 0);
          chk("round_r", r, it.r);
          chk("round_rc", rc, it.rc);
          if (it.r < 5) chk("rc_literal", rc, rc_lit[it.r]);
        end
      end
      if (done) begin
        if (q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          it = q.pop_front();
          chk("done_item_kind", it.is_done, 1);
          chk("done_latency", cyc - m_t_start, 512 + m_stalls);
          chk("en_cycles", en_cnt, 512);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    if (!done) chk("timeout_done", 0, 1);
  endtask

  task automatic wait_rn(input int rr, input int nn, input int max);
    int n = 0;
    while (!(r == 8'(rr) && nib_idx == 4'(nn)) && n < max) begin
      tick();
      n++;
    end
    if (!(r == 8'(rr) && nib_idx == 4'(nn))) chk("timeout_rn", 0, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, b, n;
    a = 1;
    b = 1;
    for (int i = 0; i < 32; i++) begin
      rc_tab[i] = (a << 4) | b;
      a = (((a >> 1) ^ a) & 1) << 3 | (a >> 1);
      b = (((b >> 1) ^ b) & 1) << 2 | (b >> 1);
    end
    rc_lit = '{'h11, 'h84, 'h42, 'h25, 'h96};

    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // plain run
    pulse_start();
    wait_done(700);
    repeat (3) tick();

    // 3-cycle stall on the last nibble of round 0
    pulse_start();
    wait_rn(0, 15, 100);
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_done(700);
    repeat (3) tick();

    // asynchronous reset in the middle of round 5
    pulse_start();
    wait_rn(5, 7, 200);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_done", done, 0);
    chk("rst_ck0", ck0, 0);
    chk("rst_r", r, 0);
    chk("rst_nib", nib_idx, 0);
    chk("rst_rc", rc, 'h11);
    tick();
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    wait_done(700);
    repeat (3) tick();

    // start held high through the run and DONE
    start = 1'b1;
    wait_done(700);
    n = 0;
    while (!busy && n < 5) begin
      tick();
      n++;
    end
    chk("restart_gap", n, 2);
    start = 1'b0;
    wait_done(700);
    repeat (3) tick();

    // stall held on the final nibble of the final round
    pulse_start();
    wait_rn(31, 15, 700);
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;
    wait_done(20);
    repeat (3) tick();

    // randomized stalls and stray starts
    repeat (4) begin
      pulse_start();
      n = 0;
      while (!done && n < 2000) begin
        stall = ($urandom_range(0, 3) == 0);
        start = $urandom_range(0, 1) == 1;
        tick();
        n++;
      end
      stall = 1'b0;
      start = 1'b0;
      if (!done) chk("timeout_random_done", 0, 1);
      repeat (2 + $urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
